// File: rtl/input_conditioner_if.sv
// CPU-side view of the input conditioner: clear strobe/mask in, conditioned
// levels, sticky event flags, packed read word and interrupt out.
interface input_conditioner_if #(
    parameter int N_IN = 8
);
    logic            clr;
    logic [N_IN-1:0] clr_mask;
    logic [N_IN-1:0] level_out;
    logic [N_IN-1:0] rise_flag;
    logic [N_IN-1:0] fall_flag;
    logic [31:0]     rdata;
    logic            irq;

    modport master (
        output clr, clr_mask,
        input  level_out, rise_flag, fall_flag, rdata, irq
    );

    modport slave (
        input  clr, clr_mask,
        output level_out, rise_flag, fall_flag, rdata, irq
    );
endinterface

// File: rtl/input_conditioner.sv
// Per-bit synchronizer, debouncer and sticky rise/fall event flags for the
// {btn, sw} pins, with a packed read word and a rise-event interrupt.
module input_conditioner #(
    parameter int N_IN     = 8,
    parameter int DEBOUNCE = 1250000,
    parameter int CNT_W    = 21
) (
    input  logic              clk_125mhz,
    input  logic              reset,
    input  logic [N_IN-1:0]   raw_in,
    input_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [N_IN-1:0]  s1_reg;
    logic [N_IN-1:0]  s2_reg;
    logic [N_IN-1:0]  level_reg;
    logic [N_IN-1:0]  level_next;
    logic [N_IN-1:0]  rise_reg;
    logic [N_IN-1:0]  rise_next;
    logic [N_IN-1:0]  fall_reg;
    logic [N_IN-1:0]  fall_next;
    logic [CNT_W-1:0] cnt_reg  [N_IN];
    logic [CNT_W-1:0] cnt_next [N_IN];
    logic             irq_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_bit
            logic differs;
            logic done;
            logic clr_hit;

            assign differs = s2_reg[gi] != level_reg[gi];
            assign done    = differs && (cnt_reg[gi] == CNT_LAST);
            assign clr_hit = bus.clr && bus.clr_mask[gi];

            // Any return to the committed level restarts the stability count.
            assign cnt_next[gi]   = (!differs || done) ? '0 : cnt_reg[gi] + CNT_W'(1);
            assign level_next[gi] = done ? s2_reg[gi] : level_reg[gi];

            // A completing event outranks a simultaneous clear so no event is lost.
            assign rise_next[gi] = (done && s2_reg[gi])  ? 1'b1 :
                                   clr_hit               ? 1'b0 : rise_reg[gi];
            assign fall_next[gi] = (done && !s2_reg[gi]) ? 1'b1 :
                                   clr_hit               ? 1'b0 : fall_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            s1_reg    <= '0;
            s2_reg    <= '0;
            level_reg <= '0;
            rise_reg  <= '0;
            fall_reg  <= '0;
            irq_reg   <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            s1_reg    <= raw_in;
            s2_reg    <= s1_reg;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            irq_reg   <= |rise_reg;
            for (int i = 0; i < N_IN; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign bus.level_out = level_reg;
    assign bus.rise_flag = rise_reg;
    assign bus.fall_flag = fall_reg;
    assign bus.rdata     = 32'({fall_reg, rise_reg, level_reg});
    assign bus.irq       = irq_reg;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a short debounce window; expected
// rdata/irq values are queued with their due cycle and checked by a monitor.
module tb_input_conditioner;
    localparam int N_IN     = 8;
    localparam int DEBOUNCE = 4;
    localparam int CNT_W    = 3;

    logic            clk_125mhz = 1'b0;
    logic            reset;
    logic [N_IN-1:0] raw_in;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_errors = 0;

    typedef struct {
        int          cyc;
        string       tag;
        bit          sel_irq;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    input_conditioner_if #(.N_IN(N_IN)) bus ();

    input_conditioner #(
        .N_IN(N_IN), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)
    ) dut (
        .clk_125mhz (clk_125mhz),
        .reset      (reset),
        .raw_in     (raw_in),
        .bus        (bus)
    );

    always #4 clk_125mhz = ~clk_125mhz;
    always @(posedge clk_125mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue an expectation d edges after the current cycle.
    task automatic expect_at(input int d, input string tag, input bit sel_irq, input logic [31:0] v);
        sb_t e;
        e.cyc = cyc + d;
        e.tag = tag;
        e.sel_irq = sel_irq;
        e.exp = v;
        sb.push_back(e);
    endtask

    always @(negedge clk_125mhz) begin
        sb_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check(e.tag, e.sel_irq ? {31'b0, bus.irq} : bus.rdata, e.exp);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_125mhz);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk_125mhz);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic pulse_clr(input logic [N_IN-1:0] mask, input int n);
        bus.clr      = 1'b1;
        bus.clr_mask = mask;
        step(n);
        bus.clr      = 1'b0;
        bus.clr_mask = '0;
    endtask

    initial begin
        reset        = 1'b1;
        raw_in       = '0;
        bus.clr      = 1'b0;
        bus.clr_mask = '0;
        step(3);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        reset = 1'b0;
        step(2);

        // 3-cycle glitch on bit 4 never commits
        for (int i = 1; i <= 12; i++) begin
            expect_at(i, "glitch_rdata", 1'b0, 32'h0);
            expect_at(i, "glitch_irq", 1'b1, 32'h0);
        end
        raw_in[4] = 1'b1;
        step(3);
        raw_in[4] = 1'b0;
        drain();

        // bit 0 rise: quiet first, then exact latency
        for (int i = 1; i <= 10; i++) expect_at(i, "idle_rdata", 1'b0, 32'h0);
        step(10);
        expect_at(5, "rise0_early", 1'b0, 32'h0);
        expect_at(6, "rise0_rdata", 1'b0, 32'h0000_0101);
        expect_at(6, "rise0_irq_early", 1'b1, 32'h0);
        expect_at(7, "rise0_irq", 1'b1, 32'h1);
        raw_in[0] = 1'b1;
        drain();

        // bit 0 fall keeps the rise flag; then clear both
        expect_at(5, "fall0_early", 1'b0, 32'h0000_0101);
        expect_at(6, "fall0_rdata", 1'b0, 32'h0001_0100);
        raw_in[0] = 1'b0;
        drain();
        expect_at(1, "clr0_rdata", 1'b0, 32'h0);
        expect_at(1, "clr0_irq_hold", 1'b1, 32'h1);
        expect_at(2, "clr0_irq_drop", 1'b1, 32'h0);
        pulse_clr(8'h01, 2);
        drain();

        // bounce on bit 7, then hold high: one event, timed from the last rise
        for (int i = 1; i <= 9; i++) expect_at(i, "bounce_quiet", 1'b0, 32'h0);
        expect_at(10, "bounce_rdata", 1'b0, 32'h0000_8080);
        expect_at(11, "bounce_irq", 1'b1, 32'h1);
        raw_in[7] = 1'b1; step(1);
        raw_in[7] = 1'b0; step(1);
        raw_in[7] = 1'b1; step(1);
        raw_in[7] = 1'b0; step(1);
        raw_in[7] = 1'b1;
        drain();
        expect_at(1, "clr7_rdata", 1'b0, 32'h0000_0080);
        expect_at(2, "clr7_irq", 1'b1, 32'h0);
        pulse_clr(8'h80, 2);
        for (int i = 1; i <= 8; i++) expect_at(i, "held7_no_event", 1'b0, 32'h0000_0080);
        drain();

        // bit 2 completes on the very edge a full clear is applied
        expect_at(5, "race_before", 1'b0, 32'h0000_0080);
        expect_at(6, "race_rdata", 1'b0, 32'h0000_0484);
        expect_at(7, "race_irq", 1'b1, 32'h1);
        expect_at(8, "race_hold", 1'b0, 32'h0000_0484);
        raw_in[2] = 1'b1;
        step(5);
        pulse_clr(8'hFF, 1);
        drain();
        expect_at(1, "clrall_rdata", 1'b0, 32'h0000_0084);
        expect_at(2, "clrall_irq", 1'b1, 32'h0);
        pulse_clr(8'hFF, 2);
        drain();

        // reset in the middle of a count with every input high
        raw_in = 8'hFF;
        step(3);
        #1 reset = 1'b1;
        #1;
        check("midrst_rdata", bus.rdata, 32'h0);
        check("midrst_irq", {31'b0, bus.irq}, 32'h0);
        @(posedge clk_125mhz);
        @(negedge clk_125mhz);
        check("midrst_hold", bus.rdata, 32'h0);
        reset = 1'b0;
        expect_at(5, "postrst_early", 1'b0, 32'h0);
        expect_at(6, "postrst_rdata", 1'b0, 32'h0000_FFFF);
        expect_at(6, "postrst_irq_early", 1'b1, 32'h0);
        expect_at(7, "postrst_irq", 1'b1, 32'h1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
